// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the MAC array sequencer.
package conv_pkg;

    localparam int unsigned DefDw     = 8;
    localparam int unsigned DefWw     = 8;
    localparam int unsigned DefCw     = 16;
    localparam int unsigned DefRow    = 8;
    localparam int unsigned DefColumn = 6;
    localparam int unsigned DefLw     = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoadW  = 3'd1,
        StSettle = 3'd2,
        StStream = 3'd3,
        StDrain  = 3'd4
    } state_e;

endpackage

// File: rtl/mac_ctrl_cnt.sv
// Clearable up-counter with terminal-count compare; saturates at all-ones.
module mac_ctrl_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_d, cnt_q;

    // Next count: clear wins over increment; hold at all-ones so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/mac_ctrl.sv
// Tile sequencer for the weight-stationary MAC array: load weights, settle,
// stream activations, drain. Optional MAC_CTRL_BIAS_EN adds a latched bias
// input that is driven onto arr_ci during STREAM.
module mac_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned DW     = DefDw,
    parameter int unsigned WW     = DefWw,
    parameter int unsigned CW     = DefCw,
    parameter int unsigned ROW    = DefRow,
    parameter int unsigned COLUMN = DefColumn,
    parameter int unsigned LW     = DefLw
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [LW-1:0]          cfg_len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic [COLUMN*WW-1:0]   wgt_s_data,
    input  logic                   wgt_s_valid,
    output logic                   wgt_s_ready,
    input  logic [ROW*DW-1:0]      act_s_data,
    input  logic                   act_s_valid,
    output logic                   act_s_ready,
    output logic [COLUMN*WW-1:0]   arr_w,
    output logic [COLUMN-1:0]      arr_w_en,
    output logic [ROW*DW-1:0]      arr_data,
    output logic                   arr_first,
    output logic                   arr_last,
    output logic                   arr_valid,
    input  logic                   arr_ready,
    output logic [COLUMN*CW-1:0]   arr_ci,
    input  logic                   res_valid,
    input  logic                   res_last,
    input  logic                   res_ready
`ifdef MAC_CTRL_BIAS_EN
    ,
    input  logic [COLUMN*CW-1:0]   bias
`endif
);

    state_e          state_d, state_q;
    logic [LW-1:0]   len_q;
    logic            done_d, done_q;
    logic            err_d, err_q;
    logic            start_ok;
    logic            w_en, s_en, a_en;
    logic            w_tc, s_tc, a_tc;
    logic [LW-1:0]   w_cnt, s_cnt, a_cnt;
    logic            unused_cnt;

    assign unused_cnt = ^{w_cnt, s_cnt};

    mac_ctrl_cnt #(.W(LW)) u_w_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (start_ok),
        .en_i     (w_en),
        .tc_val_i (LW'(ROW - 1)),
        .cnt_o    (w_cnt),
        .tc_o     (w_tc)
    );

    mac_ctrl_cnt #(.W(LW)) u_s_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (start_ok),
        .en_i     (s_en),
        .tc_val_i (LW'(ROW - 1)),
        .cnt_o    (s_cnt),
        .tc_o     (s_tc)
    );

    // len_q is nonzero for the whole tile, so len_q-1 never underflows there.
    mac_ctrl_cnt #(.W(LW)) u_a_cnt (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (start_ok),
        .en_i     (a_en),
        .tc_val_i (len_q - LW'(1)),
        .cnt_o    (a_cnt),
        .tc_o     (a_tc)
    );

    // Next-state and datapath steering; everything idles at zero by default.
    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        start_ok    = 1'b0;
        w_en        = 1'b0;
        s_en        = 1'b0;
        a_en        = 1'b0;
        wgt_s_ready = 1'b0;
        act_s_ready = 1'b0;
        arr_valid   = 1'b0;
        arr_first   = 1'b0;
        arr_last    = 1'b0;
        arr_w_en    = '0;
        arr_w       = '0;
        arr_data    = '0;
        unique case (state_q)
            StIdle: begin
                if (cfg_start) begin
                    if (cfg_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        state_d  = StLoadW;
                    end
                end
            end
            StLoadW: begin
                wgt_s_ready = 1'b1;
                if (wgt_s_valid) begin
                    arr_w    = wgt_s_data;
                    arr_w_en = '1;
                    w_en     = 1'b1;
                    if (w_tc) begin
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                s_en = 1'b1;
                if (s_tc) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                arr_valid   = act_s_valid;
                act_s_ready = arr_ready;
                arr_data    = act_s_data;
                arr_first   = (a_cnt == '0);
                arr_last    = a_tc;
                if (act_s_valid && arr_ready) begin
                    a_en = 1'b1;
                    if (a_tc) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (res_valid && res_ready && res_last) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, latched length and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (start_ok) begin
                len_q <= cfg_len;
            end
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign err  = err_q;

`ifdef MAC_CTRL_BIAS_EN
    logic [COLUMN*CW-1:0] bias_q;

    // Bias is captured with the accepted start and held for the tile.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= '0;
        end else if (start_ok) begin
            bias_q <= bias;
        end
    end

    assign arr_ci = (state_q == StStream && act_s_valid) ? bias_q : '0;
`else
    assign arr_ci = '0;
`endif

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed testbench for mac_ctrl (default build, bias feature off).
module tb_mac_ctrl;

    localparam int unsigned DW     = 8;
    localparam int unsigned WW     = 8;
    localparam int unsigned CW     = 16;
    localparam int unsigned ROW    = 8;
    localparam int unsigned COLUMN = 6;
    localparam int unsigned LW     = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_start = 1'b0;
    logic [LW-1:0]        cfg_len = '0;
    logic                 busy, done, err;
    logic [COLUMN*WW-1:0] wgt_s_data = 48'h0102_0304_0506;
    logic                 wgt_s_valid = 1'b1;
    logic                 wgt_s_ready;
    logic [ROW*DW-1:0]    act_s_data = 64'hDEAD_BEEF_CAFE_F00D;
    logic                 act_s_valid = 1'b1;
    logic                 act_s_ready;
    logic [COLUMN*WW-1:0] arr_w;
    logic [COLUMN-1:0]    arr_w_en;
    logic [ROW*DW-1:0]    arr_data;
    logic                 arr_first, arr_last, arr_valid;
    logic                 arr_ready = 1'b1;
    logic [COLUMN*CW-1:0] arr_ci;
    logic                 res_valid = 1'b0;
    logic                 res_last = 1'b0;
    logic                 res_ready = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mac_ctrl #(
        .DW(DW), .WW(WW), .CW(CW), .ROW(ROW), .COLUMN(COLUMN), .LW(LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_len     (cfg_len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .wgt_s_data  (wgt_s_data),
        .wgt_s_valid (wgt_s_valid),
        .wgt_s_ready (wgt_s_ready),
        .act_s_data  (act_s_data),
        .act_s_valid (act_s_valid),
        .act_s_ready (act_s_ready),
        .arr_w       (arr_w),
        .arr_w_en    (arr_w_en),
        .arr_data    (arr_data),
        .arr_first   (arr_first),
        .arr_last    (arr_last),
        .arr_valid   (arr_valid),
        .arr_ready   (arr_ready),
        .arr_ci      (arr_ci),
        .res_valid   (res_valid),
        .res_last    (res_last),
        .res_ready   (res_ready)
    );

    // Issue a start; returns just after the edge that enters LOAD_W.
    task automatic start_tile(input logic [LW-1:0] len);
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_len   = len;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, done, err, wgt_s_ready, act_s_ready, arr_valid, arr_first, arr_last} !== 8'h00)
        begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000000",
                     {busy, done, err, wgt_s_ready, act_s_ready, arr_valid, arr_first, arr_last});
        end
        n_cmp++;
        if (arr_w_en !== 6'h00 || arr_w !== 48'h0 || arr_data !== 64'h0 || arr_ci !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_bus: w_en=%h w=%h data=%h ci=%h, required all 0",
                     arr_w_en, arr_w, arr_data, arr_ci);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic ok;
        start_tile(4);
        for (int i = 0; i < ROW; i++) begin
            wgt_s_data = 48'h0A0B_0C0D_0E00 + 48'(i);
            #1;
            n_cmp++;
            if (arr_w_en !== 6'h3F || arr_w !== wgt_s_data || wgt_s_ready !== 1'b1
                || act_s_ready !== 1'b0 || arr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_wbeat%0d: w_en=%h w=%h wrdy=%b ardy=%b av=%b, required 3f %h 1 0 0",
                         i, arr_w_en, arr_w, wgt_s_ready, act_s_ready, arr_valid, wgt_s_data);
            end
            @(negedge clk);
        end
        ok = 1'b1;
        for (int i = 0; i < ROW; i++) begin
            #1;
            if (busy !== 1'b1 || wgt_s_ready !== 1'b0 || arr_w_en !== 6'h00
                || arr_valid !== 1'b0 || act_s_ready !== 1'b0 || err !== 1'b0) ok = 1'b0;
            // A zero-length start while busy must be ignored entirely.
            cfg_start = (i == 3);
            cfg_len   = '0;
            @(negedge clk);
        end
        cfg_start = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_settle: settle-window outputs wrong (ok=%b), required ok=1", ok);
        end
        for (int i = 0; i < 4; i++) begin
            act_s_data = {8{8'(8'hA0 + i)}};
            #1;
            n_cmp++;
            if ({arr_valid, arr_first, arr_last, act_s_ready} !== {1'b1, (i == 0), (i == 3), 1'b1}
                || arr_data !== act_s_data || arr_ci !== 96'h0) begin
                n_fail++;
                $display("FAIL basic_abeat%0d: v/f/l/rdy=%b data=%h ci=%h, required %b %h 0",
                         i, {arr_valid, arr_first, arr_last, act_s_ready}, arr_data, arr_ci,
                         {1'b1, (i == 0), (i == 3), 1'b1}, act_s_data);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (busy !== 1'b1 || arr_valid !== 1'b0 || act_s_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain: busy=%b av=%b ardy=%b done=%b, required 1 0 0 0",
                     busy, arr_valid, act_s_ready, done);
        end
        res_valid = 1'b1;
        res_ready = 1'b1;
        res_last  = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        res_ready = 1'b0;
        res_last  = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b busy=%b, required 1 0", done, busy);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    // len=1, with the res_last handshake held high from the start: it must be
    // ignored until DRAIN.
    task automatic test_len1();
        logic ok;
        res_valid = 1'b1;
        res_ready = 1'b1;
        res_last  = 1'b1;
        start_tile(1);
        ok = 1'b1;
        for (int i = 0; i < 2 * ROW; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL len1_early_res: busy/done wrong before STREAM (ok=%b), required ok=1", ok);
        end
        n_cmp++;
        if ({arr_valid, arr_first, arr_last} !== 3'b111) begin
            n_fail++;
            $display("FAIL len1_beat: v/f/l=%b, required 111", {arr_valid, arr_first, arr_last});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || arr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_drain: busy=%b done=%b av=%b, required 1 0 0", busy, done, arr_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len1_done: done=%b busy=%b, required 1 0", done, busy);
        end
        res_valid = 1'b0;
        res_ready = 1'b0;
        res_last  = 1'b0;
    endtask

    task automatic test_err();
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_len   = '0;
        @(negedge clk);
        cfg_start = 1'b0;
        #1;
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || wgt_s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_pulse: err=%b busy=%b wrdy=%b, required 1 0 0", err, busy, wgt_s_ready);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL err_once: err=%b busy=%b, required 0 0", err, busy);
        end
    endtask

    task automatic test_ready_toggle();
        logic ok;
        int   nx;
        ok = 1'b1;
        nx = 0;
        start_tile(4);
        repeat (2 * ROW) @(negedge clk);
        #1;
        for (int k = 0; k < 7; k++) begin
            arr_ready  = ((k % 2) == 0);
            act_s_data = {8{8'(8'hC0 + k)}};
            #1;
            if (act_s_ready !== arr_ready || arr_valid !== 1'b1 || arr_data !== act_s_data) ok = 1'b0;
            if (arr_ready) begin
                n_cmp++;
                if (arr_first !== (nx == 0) || arr_last !== (nx == 3)) begin
                    n_fail++;
                    $display("FAIL toggle_xfer%0d: first=%b last=%b, required %b %b",
                             nx, arr_first, arr_last, (nx == 0), (nx == 3));
                end
                nx++;
            end
            @(negedge clk);
        end
        arr_ready = 1'b1;
        #1;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_mirror: act_s_ready/arr_valid/data tracking wrong, ok=%b required 1", ok);
        end
        n_cmp++;
        if (arr_valid !== 1'b0 || busy !== 1'b1 || act_s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_drain: av=%b busy=%b ardy=%b, required 0 1 0",
                     arr_valid, busy, act_s_ready);
        end
        res_valid = 1'b1;
        res_ready = 1'b1;
        res_last  = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        res_ready = 1'b0;
        res_last  = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_done: done=%b, required 1", done);
        end
    endtask

    task automatic test_reset_mid();
        start_tile(4);
        repeat (2 * ROW) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({arr_valid, arr_first, arr_last} !== 3'b100) begin
            n_fail++;
            $display("FAIL rstmid_beat2: v/f/l=%b, required 100", {arr_valid, arr_first, arr_last});
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, wgt_s_ready, act_s_ready, arr_valid, arr_first, arr_last} !== 7'h00
            || arr_w_en !== 6'h00 || arr_data !== 64'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: ctrl=%b w_en=%h data=%h, required 0 0 0",
                     {busy, done, wgt_s_ready, act_s_ready, arr_valid, arr_first, arr_last},
                     arr_w_en, arr_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_nodone: done=%b busy=%b, required 0 0", done, busy);
        end
        start_tile(1);
        n_cmp++;
        if (wgt_s_ready !== 1'b1 || arr_w_en !== 6'h3F) begin
            n_fail++;
            $display("FAIL rstmid_reload: wrdy=%b w_en=%h, required 1 3f", wgt_s_ready, arr_w_en);
        end
        repeat (2 * ROW) @(negedge clk);
        #1;
        n_cmp++;
        if ({arr_valid, arr_first, arr_last} !== 3'b111) begin
            n_fail++;
            $display("FAIL rstmid_clean: v/f/l=%b, required 111", {arr_valid, arr_first, arr_last});
        end
        res_valid = 1'b1;
        res_ready = 1'b1;
        res_last  = 1'b1;
        repeat (2) @(negedge clk);
        res_valid = 1'b0;
        res_ready = 1'b0;
        res_last  = 1'b0;
        #1;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_done: done=%b busy=%b, required 1 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len1();
        test_err();
        test_ready_toggle();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule
